// File: rtl/ram_port_ctrl.sv
// Host/fill arbiter for a 32K x 8 single-port synchronous RAM.
// Host accesses are served only in IDLE; a fill sweep writes one constant byte to 0..FILL_LAST.
module ram_port_ctrl #(
  parameter logic [14:0] FILL_LAST = 15'h7FFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [14:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  input  logic        fill_start,
  input  logic [7:0]  fill_value,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        ram_ce,
  output logic        ram_oce,
  output logic        ram_reset,
  output logic        ram_wre,
  output logic [14:0] ram_ad,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state, state_nxt;
  logic [14:0] cnt, cnt_nxt;
  logic [7:0]  fval;
  logic [7:0]  rdata_q;
  logic        rd_pend;
  logic        acc;

  assign ram_oce   = 1'b1;
  assign ram_reset = 1'b0;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = 1'b0;
    acc       = 1'b0;
    ram_ce    = 1'b0;
    ram_wre   = 1'b0;
    ram_ad    = cnt;
    ram_din   = fval;
    fill_busy = 1'b0;
    fill_done = 1'b0;
    case (state)
      IDLE: begin
        req_ready = !fill_start;
        acc       = req_valid && !fill_start;
        ram_ce    = acc;
        ram_wre   = acc && req_we;
        ram_ad    = req_addr;
        ram_din   = req_wdata;
        if (fill_start) begin
          state_nxt = FILL;
          cnt_nxt   = '0;
        end
      end
      FILL: begin
        ram_ce    = 1'b1;
        ram_wre   = 1'b1;
        fill_busy = 1'b1;
        if (cnt == FILL_LAST) state_nxt = DONE;
        else                  cnt_nxt   = cnt + 15'd1;
      end
      DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // The RAM pins must stay quiet while reset is held, even though IDLE passes req_valid through.
    if (!reset_n) begin
      req_ready = 1'b0;
      acc       = 1'b0;
      ram_ce    = 1'b0;
      ram_wre   = 1'b0;
      fill_busy = 1'b0;
      fill_done = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      cnt     <= '0;
      fval    <= '0;
      rd_pend <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      rd_pend <= acc && !req_we;
      if (state == IDLE && fill_start) fval <= fill_value;
      if (rd_pend) rdata_q <= ram_dout;
    end
  end

  // RAM data is valid in the cycle after the access; pass it straight through, then hold it.
  assign rsp_valid = rd_pend;
  assign rsp_rdata = rd_pend ? ram_dout : rdata_q;

endmodule
